// File: rtl/delta_ram_reader.sv
`default_nettype none
// ============================================================================
// Module   : delta_ram_reader
// Purpose  : Read-side controller for the delta-coefficient SRAM wrapper.
//            Walks a contiguous address range that wraps at the top of the
//            SRAM and streams each word out on a valid/ready interface. The
//            SRAM's 1-cycle registered read latency is hidden behind a
//            2-entry output buffer that has a fall-through path. The single
//            SRAM port is yielded to the writer whenever a write is active.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            start               one-cycle pulse, launches a burst when idle
//            base_addr, len      burst first address / word count (0..DEPTH)
//            busy, done          burst in progress / one-cycle completion
//            ram_write_en        writer owns the SRAM port this cycle
//            read_en, addr_r     SRAM read request
//            ram_data            SRAM read data, valid the cycle after read_en
//            out_valid, out_data, out_ready   output stream
//            stall_cnt           (optional) write-collision stall counter
// Options  : DELTA_READER_STALL_CNT_EN adds the 16-bit stall_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module delta_ram_reader #(
  parameter int SRAM_DEPTH_BIT = 6,
  parameter int SRAM_DEPTH     = 2**SRAM_DEPTH_BIT,
  parameter int SRAM_WIDTH     = 28
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SRAM_DEPTH_BIT-1:0] base_addr,
  input  logic [SRAM_DEPTH_BIT:0]   len,
  output logic                      busy,
  output logic                      done,
  input  logic                      ram_write_en,
  output logic                      read_en,
  output logic [SRAM_DEPTH_BIT-1:0] addr_r,
  input  logic [SRAM_WIDTH-1:0]     ram_data,
  output logic                      out_valid,
  output logic [SRAM_WIDTH-1:0]     out_data,
  input  logic                      out_ready
`ifdef DELTA_READER_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam logic [SRAM_DEPTH_BIT:0] c_depth = (SRAM_DEPTH_BIT+1)'(SRAM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;

  logic [SRAM_DEPTH_BIT-1:0] r_base;
  logic [SRAM_DEPTH_BIT-1:0] r_addr_last;
  logic [SRAM_DEPTH_BIT-1:0] w_addr_issue;
  logic [SRAM_DEPTH_BIT:0]   r_len;
  logic [SRAM_DEPTH_BIT:0]   r_issued;
  logic [SRAM_DEPTH_BIT:0]   w_issued_next;
  logic [SRAM_DEPTH_BIT:0]   w_len_clamped;

  // r_inflight: a read was issued last cycle, so ram_data is valid now.
  logic                      r_inflight;

  logic [SRAM_WIDTH-1:0]     r_buf [2];
  logic                      r_rd_ptr;
  logic                      r_wr_ptr;
  logic [1:0]                r_count;
  logic [1:0]                w_count_next;
  logic [1:0]                w_occ;

  logic                      w_start_ok;
  logic                      w_bypass;
  logic                      w_pop;
  logic                      w_pop_buf;
  logic                      w_push;

  // --------------------------------------------------------------------------
  // Control and datapath decode
  // --------------------------------------------------------------------------
  assign w_start_ok    = (r_state == S_IDLE) && start;
  assign w_len_clamped = (len > c_depth) ? c_depth : len;

  assign busy = (r_state != S_IDLE) || w_start_ok;
  assign done = (r_state == S_DONE);

  // Words already arrived plus the word arriving now. Issuing only while this
  // is below 2 means every returning word has a buffer slot.
  assign w_occ = r_count + {1'b0, r_inflight};

  assign read_en = (r_state == S_READ) && (r_issued < r_len) &&
                   !ram_write_en && (w_occ < 2'd2);

  // Truncation to SRAM_DEPTH_BIT bits performs the modulo-depth wrap.
  assign w_addr_issue  = r_base + r_issued[SRAM_DEPTH_BIT-1:0];
  assign addr_r        = read_en ? w_addr_issue : r_addr_last;
  assign w_issued_next = r_issued + {{SRAM_DEPTH_BIT{1'b0}}, read_en};

  // With an empty buffer the arriving SRAM word is presented directly, which
  // gives 1-cycle read_en->out_valid latency and 1 word/cycle throughput.
  // If it is not taken it is captured, so out_data stays stable afterwards.
  assign w_bypass  = (r_count == 2'd0) && r_inflight;
  assign out_valid = (r_count != 2'd0) || r_inflight;
  assign out_data  = w_bypass ? ram_data : r_buf[r_rd_ptr];

  assign w_pop     = out_valid && out_ready;
  assign w_pop_buf = w_pop && (r_count != 2'd0);
  assign w_push    = r_inflight && !(w_bypass && w_pop);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop_buf})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (w_len_clamped == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (w_issued_next == r_len) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // No reads are issued here, so an empty next-cycle buffer means the
        // final handshake is happening now and done follows next cycle.
        if (w_count_next == 2'd0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Burst bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_addr_last <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= read_en;
      if (w_start_ok) begin
        r_base   <= base_addr;
        r_len    <= w_len_clamped;
        r_issued <= '0;
      end else begin
        r_issued <= w_issued_next;
      end
      if (read_en) begin
        r_addr_last <= w_addr_issue;
      end
    end
  end

  // --------------------------------------------------------------------------
  // 2-entry output FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_buf[i] <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= ram_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_buf) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_next;
    end
  end

`ifdef DELTA_READER_STALL_CNT_EN
  // --------------------------------------------------------------------------
  // Write-collision stall counter (saturating)
  // --------------------------------------------------------------------------
  logic [15:0] r_stall_cnt;

  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_READ) && (r_issued < r_len) && ram_write_en &&
                 (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_delta_ram_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_delta_ram_reader
// Purpose  : Self-checking bench for delta_ram_reader. A table of directed
//            bursts and a set of random bursts are checked against a
//            reference built from the burst definition: the expected stream
//            is mem[(base+i) % DEPTH] for i < len, done must follow the last
//            handshake by one cycle, and at most 2 words may be outstanding.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delta_ram_reader;

  localparam int DB    = 6;
  localparam int DEPTH = 64;
  localparam int W     = 28;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DB-1:0] base_addr = '0;
  logic [DB:0]   len = '0;
  logic          busy;
  logic          done;
  logic          ram_write_en = 1'b0;
  logic          read_en;
  logic [DB-1:0] addr_r;
  logic [W-1:0]  ram_data = '0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;
`ifdef DELTA_READER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  delta_ram_reader #(
    .SRAM_DEPTH_BIT(DB),
    .SRAM_DEPTH    (DEPTH),
    .SRAM_WIDTH    (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .ram_write_en(ram_write_en),
    .read_en     (read_en),
    .addr_r      (addr_r),
    .ram_data    (ram_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
`ifdef DELTA_READER_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: registered read, data valid the cycle after read_en.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (read_en) ram_data <= mem[addr_r];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  typedef struct {
    int base;
    int len;
    int rmode;     // 0: always ready, 1: 1,0,0 pattern, 2: random
    int wmode;     // 0: no writes, 1: writes in cycles 2..4, 2: random
    int exp_done;  // cycle of done after start (-1: not checked)
    int exp_first; // first read address (-1: none)
    int exp_last;  // last read address
  } vec_t;

  function automatic logic ready_of(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((c - 1) % 3) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  function automatic logic wr_of(input int mode, input int c);
    if (mode == 0) return 1'b0;
    if (mode == 1) return (c >= 2) && (c <= 4);
    return $urandom_range(0, 4) == 0;
  endfunction

  task automatic run_burst(input int vi, input vec_t v);
    logic [W-1:0] q[$];
    int     issued = 0, hs = 0, c = 0, last_hs = -1;
    int     first_a = -1, last_a = -1, stalls = 0;
    bit     prev_stall = 0, fin = 0;
    logic [W-1:0] prev_data = '0;
    string  tag;
    tag = $sformatf("v%0d", vi);
    for (int i = 0; i < v.len; i++) q.push_back(mem[(v.base + i) % DEPTH]);

    @(posedge clk); #1;
    start = 1'b1; base_addr = DB'(v.base); len = (DB+1)'(v.len);
    out_ready = 1'b1; ram_write_en = 1'b0;
    @(negedge clk);
    chk({tag, "_busy_on_start"}, busy, 1);
    chk({tag, "_no_read_on_start"}, read_en, 0);

    while (!fin) begin
      @(posedge clk); #1;
      start = 1'b0;
      c++;
      out_ready    = ready_of(v.rmode, c);
      ram_write_en = wr_of(v.wmode, c);
      @(negedge clk);
      if (prev_stall) begin
        chk({tag, "_stalled_valid"}, out_valid, 1);
        chk({tag, "_stalled_data"}, out_data, prev_data);
      end
      if (ram_write_en) chk({tag, "_no_read_during_write"}, read_en, 0);
      if (read_en) begin
        chk({tag, "_addr"}, addr_r, (v.base + issued) % DEPTH);
        if (first_a < 0) first_a = addr_r;
        last_a = addr_r;
        issued++;
      end else if (ram_write_en && issued < v.len) begin
        stalls++;
      end
      if ((issued - hs) > 2) fail_now({tag, "_outstanding_gt2"});
      if (out_valid && out_ready) begin
        if (q.size() == 0) fail_now({tag, "_extra_word"});
        else chk({tag, "_data"}, out_data, q.pop_front());
        hs++;
        last_hs = c;
      end
      if (done) begin
        chk({tag, "_done_after_last_hs"}, c, (v.len == 0) ? 1 : last_hs + 1);
        chk({tag, "_words_left"}, q.size(), 0);
        chk({tag, "_issued"}, issued, v.len);
        chk({tag, "_busy_at_done"}, busy, 1);
        if (v.exp_done >= 0) chk({tag, "_done_cycle"}, c, v.exp_done);
        if (v.exp_first >= 0) begin
          chk({tag, "_first_addr"}, first_a, v.exp_first);
          chk({tag, "_last_addr"}, last_a, v.exp_last);
        end
`ifdef DELTA_READER_STALL_CNT_EN
        chk({tag, "_stall_cnt"}, stall_cnt, stalls);
`endif
        fin = 1;
      end else if (!busy) begin
        fail_now({tag, "_busy_dropped"});
        fin = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (!fin && c > 1000) begin
        fail_now({tag, "_timeout"});
        fin = 1;
      end
    end

    @(posedge clk); #1;
    out_ready = 1'b0; ram_write_en = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_done"}, done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t rv;
    int   hs;
    int   guard;

    vecs[0] = '{base: 5,  len: 4,  rmode: 0, wmode: 0, exp_done: 6,  exp_first: 5,  exp_last: 8};
    vecs[1] = '{base: 62, len: 4,  rmode: 0, wmode: 0, exp_done: 6,  exp_first: 62, exp_last: 1};
    vecs[2] = '{base: 0,  len: 0,  rmode: 0, wmode: 0, exp_done: 1,  exp_first: -1, exp_last: -1};
    vecs[3] = '{base: 0,  len: 8,  rmode: 1, wmode: 0, exp_done: -1, exp_first: 0,  exp_last: 7};
    vecs[4] = '{base: 0,  len: 8,  rmode: 0, wmode: 1, exp_done: 13, exp_first: 0,  exp_last: 7};
    vecs[5] = '{base: 33, len: 64, rmode: 0, wmode: 0, exp_done: 66, exp_first: 33, exp_last: 32};
    vecs[6] = '{base: 63, len: 1,  rmode: 0, wmode: 0, exp_done: 3,  exp_first: 63, exp_last: 63};

    for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom());

    // Reset state
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_read_en", read_en, 0);
    chk("reset_addr_r", addr_r, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_burst(i, vecs[i]);

    // Asynchronous reset in the middle of a 6-word burst
    @(posedge clk); #1;
    start = 1'b1; base_addr = '0; len = 7'd6; out_ready = 1'b1; ram_write_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0;
    guard = 0;
    while (hs < 2 && guard < 50) begin
      @(negedge clk);
      if (out_valid && out_ready) hs++;
      guard++;
    end
    chk("rst_two_words_seen", hs, 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_done", done, 0);
    chk("rst_async_read_en", read_en, 0);
    chk("rst_async_addr_r", addr_r, 0);
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_out_data", out_data, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    rv = '{base: 10, len: 2, rmode: 0, wmode: 0, exp_done: 4, exp_first: 10, exp_last: 11};
    run_burst(100, rv);

    // Randomized bursts
    for (int k = 0; k < 20; k++) begin
      rv.base      = $urandom_range(0, DEPTH - 1);
      rv.len       = $urandom_range(0, DEPTH);
      rv.rmode     = 2;
      rv.wmode     = 2;
      rv.exp_done  = -1;
      rv.exp_first = (rv.len == 0) ? -1 : rv.base;
      rv.exp_last  = (rv.base + rv.len - 1) % DEPTH;
      run_burst(200 + k, rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
